// File: rtl/fifo_burst_drain_checker.sv
// Read-side consumer for the async FIFO. It drains TOTAL_WORDS words in bursts
// of at most BURST_LEN, starting a burst only once the read water level covers
// it, and checks each returned word against a descending counter that starts at
// all-ones.
//
// Ports:
//   clk, tb_rst     read clock, asynchronous active-high reset
//   start           one-cycle pulse, accepted only in IDLE or DONE
//   rd_data         FIFO read data, valid RD_LATENCY cycles after rd_en
//   rd_empty        FIFO empty flag
//   rd_water_level  FIFO read-side fill level
//   rd_en           FIFO read enable (combinational from state and rd_empty)
//   out_data        checked word forwarded downstream, qualified by out_valid
//   busy            drain in progress
//   done            drain complete, held until the next accepted start
//   err_flag        sticky mismatch flag since the last start
//   err_cnt         saturating mismatch count
//   words_read      words received and checked since the last start
module fifo_burst_drain_checker #(
  parameter int unsigned DEPTH_W     = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned TOTAL_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned ERR_W       = 3
) (
  input  logic              clk,
  input  logic              tb_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_empty,
  input  logic [DEPTH_W:0]  rd_water_level,
  output logic              rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [15:0]       words_read
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BEAT_W = DEPTH_W + 1;
  localparam logic [CNT_W-1:0] TOTAL   = CNT_W'(TOTAL_WORDS);
  localparam logic [CNT_W-1:0] BURST   = CNT_W'(BURST_LEN);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  // Last stage of the read-return pipe; its bit marks rd_data valid this cycle.
  localparam logic [RD_LATENCY-1:0] V_BIT = RD_LATENCY'(1) << (RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e                state_q,      state_d;
  logic [CNT_W-1:0]      remaining_q,  remaining_d;
  logic [BEAT_W-1:0]     beat_q,       beat_d;
  logic [DATA_W-1:0]     expected_q,   expected_d;
  logic [RD_LATENCY-1:0] pipe_q,       pipe_d;
  logic [DATA_W-1:0]     out_data_q,   out_data_d;
  logic                  out_valid_q,  out_valid_d;
  logic                  busy_q,       busy_d;
  logic                  done_q,       done_d;
  logic                  err_flag_q,   err_flag_d;
  logic [ERR_W-1:0]      err_cnt_q,    err_cnt_d;
  logic [CNT_W-1:0]      words_read_q, words_read_d;

  logic             rd_en_c;
  logic             v_c;
  logic             pending_c;
  logic [CNT_W-1:0] need_c;

  // Read enable: only inside a burst, never against an empty FIFO.
  assign rd_en_c   = (state_q == S_BURST) && !rd_empty;
  assign v_c       = |(pipe_q & V_BIT);
  // Reads still in flight beyond the one returning this cycle.
  assign pending_c = |(pipe_q & ~V_BIT);
  assign need_c    = (remaining_q < BURST) ? remaining_q : BURST;

  // Next-state, return-path checking and output computation.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    beat_d       = beat_q;
    expected_d   = expected_q;
    pipe_d       = (pipe_q << 1) | RD_LATENCY'(rd_en_c);
    out_data_d   = out_data_q;
    out_valid_d  = v_c;
    busy_d       = busy_q;
    done_d       = done_q;
    err_flag_d   = err_flag_q;
    err_cnt_d    = err_cnt_q;
    words_read_d = words_read_q;

    // Returned word: forward, count and compare against the pattern.
    if (v_c) begin
      out_data_d   = rd_data;
      words_read_d = words_read_q + CNT_W'(1);
      expected_d   = expected_q - DATA_W'(1);
      if (rd_data != expected_q) begin
        err_flag_d = 1'b1;
        if (err_cnt_q != ERR_MAX) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          remaining_d  = TOTAL;
          expected_d   = '1;
          err_cnt_d    = '0;
          err_flag_d   = 1'b0;
          words_read_d = '0;
          done_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (CNT_W'(rd_water_level) >= need_c) begin
          beat_d  = BEAT_W'(need_c);
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (rd_en_c) begin
          beat_d      = beat_q - BEAT_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          if (beat_q == BEAT_W'(1)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!pending_c) begin
          if (remaining_q == '0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      beat_q       <= '0;
      expected_q   <= '1;
      pipe_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_flag_q   <= 1'b0;
      err_cnt_q    <= '0;
      words_read_q <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      beat_q       <= beat_d;
      expected_q   <= expected_d;
      pipe_q       <= pipe_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_flag_q   <= err_flag_d;
      err_cnt_q    <= err_cnt_d;
      words_read_q <= words_read_d;
    end
  end

  assign rd_en      = rd_en_c;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_flag   = err_flag_q;
  assign err_cnt    = err_cnt_q;
  assign words_read = words_read_q;

endmodule
